iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider for RV M-extension DIV/DIVU/REM/REMU, located in the Execute stage beside the ALU.
- Produces div_stalled, which the hazard unit consumes as its divider-busy input to stall the F, D and E stages while a divide is in flight.
- Drives the quotient or remainder to the EX/MEM result mux in the cycle the stall drops.

Parameters:
- XLEN, 32, operand and result width in bits.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  a valid M-extension divide/remainder instruction is in E.
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  dividend (forwarded rs1 value).
- op_b  input  XLEN  divisor (forwarded rs2 value).
- kill  input  1  abort the operation in flight (E flush).
- hold  input  1  downstream memory stall; freeze the result.
- div_stalled  output  1  divider needs the pipeline held.
- done  output  1  result valid this cycle.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset: state IDLE; div_stalled=0, done=0, result=0; counter and all datapath registers cleared.
- Reset takes priority over every other input; reset during BUSY or DONE returns to IDLE with no done pulse.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, cycle T0:
  - Latch funct3, the operand signs, and |op_a| and |op_b|. Magnitudes apply to signed ops only; unsigned ops take the operands raw.
  - Zero the remainder register and load the counter with XLEN.
- Special cases are detected at T0 and go IDLE->DONE directly, with no iteration:
  - Divisor zero: quotient = all ones, remainder = op_a.
  - Signed overflow (op_a = 1 followed by XLEN-1 zeros, op_b = all ones, DIV/REM only): quotient = op_a, remainder = 0.
- Normal case: IDLE->BUSY.
- div_stalled is combinational:
  - 1 when (IDLE and start and not kill), or when state is BUSY.
  - 0 in DONE, so the hazard unit releases E in the result cycle.
- BUSY iteration, one bit per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - divisor on XLEN+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1.
  - Decrement the counter. When the counter reaches 1, go to DONE.
- Normal latency:
  - div_stalled is high for T0..T_XLEN (XLEN+1 cycles).
  - done is high at T_{XLEN+1}.
- Special-case latency: div_stalled is high in T0 only; done is high at T1.
- Sign fix-up is applied when forming result in DONE:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - REM/REMU select the remainder; DIV/DIVU select the quotient.
- DONE:
  - done=1 and result is valid.
  - start is ignored, because the same instruction is still in E this cycle.
  - If hold=1, stay in DONE with result and done stable. Otherwise go to IDLE next cycle.
- result holds its last value in IDLE. done=0 in IDLE and BUSY.
- kill=1 in any state: go to IDLE next cycle, no done, result unchanged. kill in IDLE with start=1 does not start an operation.
- Back-to-back divides: a new start is accepted in the IDLE cycle immediately after DONE.
- hold has no effect in IDLE or BUSY. Iteration continues while the memory stall is active.

Test Plan:
- DIVU op_a=100, op_b=7, XLEN=32 -> div_stalled high 33 cycles, then done=1 with result=14; REMU with the same operands -> result=2, same timing.
- DIV op_a=-7, op_b=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFF (-1); DIV op_a=7, op_b=-2 -> result=0xFFFFFFFD.
- DIVU op_a=5, op_b=0 -> div_stalled one cycle, done next cycle with result=0xFFFFFFFF; REM op_a=-5, op_b=0 -> result=0xFFFFFFFB.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000 after 1 stall cycle; REM with the same operands -> result=0.
- Start DIVU 1000/3, assert kill at cycle 10 -> IDLE next cycle, no done pulse. Then DIVU 9/3 -> result=3 after the normal latency.
- Hold asserted for 3 cycles on reaching DONE -> done and result (=14) stable all 3 cycles, IDLE after hold drops. Separately, rst during BUSY -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - radix-2 restoring divider for RV M-extension DIV/DIVU/REM/REMU
module iterative_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    input  logic            hold,
    output logic            div_stalled,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [XLEN-1:0] rem_q,      rem_d;
    logic [XLEN-1:0] quo_q,      quo_d;
    logic [XLEN-1:0] dvs_q,      dvs_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic            is_rem_q,   is_rem_d;
    logic            quo_neg_q,  quo_neg_d;
    logic            rem_neg_q,  rem_neg_d;
    logic [XLEN-1:0] result_q,   result_d;

    // funct3[2] is always 1 for the divide group; only the low bits select the op
    logic            unused_funct3;
    assign unused_funct3 = funct3[2];

    logic            signed_op;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    assign signed_op = ~funct3[0];
    assign sign_a    = signed_op & op_a[XLEN-1];
    assign sign_b    = signed_op & op_b[XLEN-1];
    assign abs_a     = sign_a ? -op_a : op_a;
    assign abs_b     = sign_b ? -op_b : op_b;
    assign div_zero  = (op_b == '0);
    assign overflow  = signed_op && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // One restoring step: bring the next dividend bit into the partial remainder
    logic [XLEN:0]   rem_ext;
    logic [XLEN:0]   trial;
    logic            trial_neg;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_res;

    assign rem_ext   = {rem_q, quo_q[XLEN-1]};
    assign trial     = rem_ext - {1'b0, dvs_q};
    assign trial_neg = trial[XLEN];
    assign rem_step  = trial_neg ? rem_ext[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], ~trial_neg};
    assign quo_fix   = quo_neg_q ? -quo_step : quo_step;
    assign rem_fix   = rem_neg_q ? -rem_step : rem_step;
    assign final_res = is_rem_q ? rem_fix : quo_fix;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    is_rem_d  = funct3[1];
                    quo_neg_d = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    dvs_d     = abs_b;
                    cnt_d     = CNT_W'(XLEN);
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    // Last step: fold sign fix-up in so result is ready on entry to DONE
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (kill || !hold) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    // DONE drops the stall so the hazard unit releases E in the result cycle
    assign div_stalled = ((state_q == S_IDLE) && start && !kill) || (state_q == S_BUSY);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - randomized self-checking bench for iterative_divider
module tb_iterative_divider;

    localparam int XLEN     = 32;
    localparam int NORM_LAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        hold;
    logic        div_stalled;
    logic        done;
    logic [31:0] result;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    iterative_divider #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .funct3      (funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .kill        (kill),
        .hold        (hold),
        .div_stalled (div_stalled),
        .done        (done),
        .result      (result)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r;
        case (f3)
            3'd4:    r = (b == 0) ? -1 : sa / sb;
            3'd5:    r = (b == 0) ? -1 : longint'(a / b);
            3'd6:    r = (b == 0) ? sa : sa % sb;
            default: r = (b == 0) ? longint'(a) : longint'(a % b);
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    // Called on a negedge; returns on the negedge of the cycle after done
    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output int lat, output logic [31:0] res);
        stalls = 0;
        lat    = -1;
        res    = 'x;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (div_stalled) stalls++;
            if (done) begin
                lat = c;
                res = result;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; hold = 1'b0;
        funct3 = 3'd4; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (div_stalled !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", div_stalled); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  vf [11] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd5, 3'd6, 3'd4, 3'd6, 3'd5, 3'd5};
        logic [31:0] va [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                                 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0,
                                 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        int stalls, lat, exp_lat;
        logic [31:0] res, exp;
        for (int i = 0; i < 11; i++) begin
            exp     = ref_result(vf[i], va[i], vb[i]);
            exp_lat = ref_latency(vf[i], va[i], vb[i]);
            drive_op(vf[i], va[i], vb[i], stalls, lat, res);
            total++; if (res !== exp) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, res, exp); end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            total++; if (stalls != exp_lat) begin bad++; $display("FAIL dir%0d_stalls: got %0d want %0d", i, stalls, exp_lat); end
            #1;
            total++; if (done !== 1'b0 || div_stalled !== 1'b0) begin
                bad++; $display("FAIL dir%0d_idle_after: got done=%b stall=%b want 0 0", i, done, div_stalled);
            end
            total++; if (result !== exp) begin bad++; $display("FAIL dir%0d_result_held: got %h want %h", i, result, exp); end
            @(negedge clk);
            last_res = exp;
        end
    endtask

    task automatic test_kill();
        bit saw_done, saw_stall;
        int stalls, lat;
        logic [31:0] res;
        start = 1'b1; kill = 1'b1; funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5;
        #1;
        total++; if (div_stalled !== 1'b0) begin bad++; $display("FAIL kill_idle_stall: got %b want 0", div_stalled); end
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        #1;
        total++; if (done !== 1'b0 || div_stalled !== 1'b0) begin
            bad++; $display("FAIL kill_idle_nostart: got done=%b stall=%b want 0 0", done, div_stalled);
        end
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        saw_done = 0; saw_stall = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) saw_done = 1;
            if (div_stalled) saw_stall = 1;
            @(negedge clk);
        end
        total++; if (saw_done) begin bad++; $display("FAIL kill_no_done: got 1 want 0"); end
        total++; if (saw_stall) begin bad++; $display("FAIL kill_no_stall: got 1 want 0"); end
        total++; if (result !== last_res) begin bad++; $display("FAIL kill_result_kept: got %h want %h", result, last_res); end
        drive_op(3'd5, 32'd9, 32'd3, stalls, lat, res);
        total++; if (res !== 32'd3) begin bad++; $display("FAIL kill_then_divu: got %h want 3", res); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL kill_then_lat: got %0d want %0d", lat, NORM_LAT); end
        last_res = 32'd3;
    endtask

    task automatic test_hold();
        int lat = -1;
        hold = 1'b1;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (done) begin lat = c; break; end
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL hold_busy_lat: got %0d want %0d", lat, NORM_LAT); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_done%0d: got %b want 1", k, done); end
            total++; if (result !== 32'd14) begin bad++; $display("FAIL hold_result%0d: got %h want e", k, result); end
            total++; if (div_stalled !== 1'b0) begin bad++; $display("FAIL hold_stall%0d: got %b want 0", k, div_stalled); end
        end
        hold = 1'b0;
        @(negedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_release: got %b want 0", done); end
        total++; if (result !== 32'd14) begin bad++; $display("FAIL hold_idle_result: got %h want e", result); end
        @(negedge clk);
        last_res = 32'd14;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  vf [4] = '{3'd4, 3'd5, 3'd7, 3'd6};
        logic [31:0] va [4] = '{32'd1234567, 32'd77, 32'hDEAD_BEEF, 32'hFFFF_FF00};
        logic [31:0] vb [4] = '{32'hFFFF_FFF3, 32'd0, 32'd1000, 32'd7};
        int stalls, lat, exp_lat;
        logic [31:0] res, exp;
        for (int i = 0; i < 4; i++) begin
            exp     = ref_result(vf[i], va[i], vb[i]);
            exp_lat = ref_latency(vf[i], va[i], vb[i]);
            drive_op(vf[i], va[i], vb[i], stalls, lat, res);
            total++; if (res !== exp) begin bad++; $display("FAIL b2b%0d_result: got %h want %h", i, res, exp); end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            last_res = exp;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int stalls, lat, exp_lat, sel;
        for (int i = 0; i < 30; i++) begin
            f3  = 3'd4 + 3'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    b = 32'($urandom_range(1, 20));
                4:       b = -32'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp     = ref_result(f3, a, b);
            exp_lat = ref_latency(f3, a, b);
            drive_op(f3, a, b, stalls, lat, res);
            total++; if (res !== exp) begin
                bad++; $display("FAIL rnd%0d_result: f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, exp);
            end
            total++; if (stalls != exp_lat || lat != exp_lat) begin
                bad++; $display("FAIL rnd%0d_timing: got stalls=%0d lat=%0d want %0d", i, stalls, lat, exp_lat);
            end
            last_res = exp;
        end
    endtask

    task automatic test_reset_busy();
        bit saw_done = 0;
        int stalls, lat;
        logic [31:0] res;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (div_stalled !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_busy_ctrl: got stall=%b done=%b want 0 0", div_stalled, done);
        end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_busy_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) saw_done = 1;
            @(negedge clk);
        end
        total++; if (saw_done) begin bad++; $display("FAIL rst_busy_no_done: got 1 want 0"); end
        drive_op(3'd4, 32'hFFFF_FF9C, 32'd7, stalls, lat, res);
        total++; if (res !== 32'hFFFF_FFF2) begin bad++; $display("FAIL rst_recover: got %h want fffffff2", res); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_kill();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
